lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update datapath. It scans one neuron per enabled cycle.
- Per-neuron state: membrane potential, pending input current, refractory counter.
- Per frame: emits one spike vector.
- Sits behind the TinyTapeout top wrapper. The wrapper maps ui_in/uio_in to input and config writes, and uo_out to spikes.

Parameters:
NUM_NEURONS, 4, neuron count (power of two, >=2)
WIDTH, 8, potential/current/threshold width (unsigned)
REFRAC_W, 3, refractory counter width
IDX_W, $clog2(NUM_NEURONS), neuron index width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  scan enable; low freezes the scanner
in_valid  in  1  input current write strobe
in_idx  in  IDX_W  target neuron of input write
in_current  in  WIDTH  current added to target's pending input
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=threshold, 1=leak_shift, 2=refrac_period, 3=mode
cfg_data  in  WIDTH  config write data (low bits used where narrower)
spike_out  out  NUM_NEURONS  spike vector of last completed frame
frame_done  out  1  one-cycle pulse when spike_out updates
potential_out  out  WIDTH  potential of neuron just updated (debug)

Behaviour:
- Reset: rst_n sampled low at clk edge clears all state.
  - All potentials, pending inputs and refractory counters = 0.
  - Scan index = 0; spike_out = 0; frame_done = 0; potential_out = 0.
  - Config defaults: threshold = 2^(WIDTH-1), leak_shift = 2, refrac_period = 2, mode = 0.
- Reset mid-frame: the partial frame is discarded. No frame_done is emitted.
- Config writes: take effect the cycle after the write. Fields:
  - leak_shift is 3 bits.
  - refrac_period is REFRAC_W bits.
  - mode bit0: 0 = reset-to-zero, 1 = subtractive reset.
- Input write (in_valid): pending[in_idx] = sat(pending[in_idx] + in_current) to 2^WIDTH-1. Inputs and config writes are accepted regardless of ena.
- Scan: each cycle with ena=1 updates neuron i = scan index, then index increments mod NUM_NEURONS. One frame = NUM_NEURONS enabled cycles.
- Update of neuron i, all arithmetic in WIDTH+1 bits:
  - If refrac[i] != 0: refrac[i]--, V[i] = 0, pending[i] consumed and discarded, no spike.
  - Else: leak = (leak_shift == 0) ? 0 : V >> leak_shift. Vn = sat(V - leak + pending[i]).
  - If Vn >= threshold: spike bit i set in the frame accumulator. V[i] = (mode0 ? Vn - threshold : 0). refrac[i] = refrac_period.
  - Else: V[i] = Vn.
  - pending[i] consumed (cleared).
- Simultaneous in_valid to the neuron being updated: the new in_current is the post-consumption pending value. It is applied next frame, not lost and not added this frame.
- Frame end: on the update of index NUM_NEURONS-1:
  - spike_out <= accumulator including this cycle's result; frame_done pulses 1 cycle later (registered, aligned with spike_out).
  - Accumulator clears.
  - spike_out holds until the next frame end.
- potential_out: registered new V of the neuron just updated; 1-cycle latency after its update cycle.
- ena=0: no state changes except input/config writes; outputs hold.
- Threshold 0: every non-refractory neuron spikes every frame. This is legal.

Decomposition:
- Package lif_pkg holds:
  - cfg address constants CFG_THRESH/CFG_LEAK/CFG_REFRAC/CFG_MODE;
  - default values;
  - MODE_SUBTRACT bit index;
  - the saturating-add function.
- Sub-module lif_update: combinational single-neuron datapath. Inputs V, pending, refrac, config. Outputs Vn, refrac_n, spike.
- The top holds the state arrays, scanner, input/config logic and frame accumulator.

Test Plan:
- Defaults, WIDTH=8, NUM_NEURONS=4. Write 64 to neuron 0 before each frame.
  - Potentials 64, 112, 148→spike (spike_out=4'b0001 at frame 3 end).
  - V=0, then 2 refractory frames with V=0, inputs ignored; frame 6 V=64.
- mode=1, same stimulus: frame 3 spikes and V=148-128=20. Frame 4 refractory sets V=0.
- Input write to neuron 2 colliding with its update cycle (pending=10 + new 30): this frame adds 10, next frame adds 30.
- Saturation: threshold=255, leak_shift=0, V=200, pending 200+100 (sat 255). Update gives Vn=255 and a spike; no wrap.
- Reset asserted mid-frame after 2 updates: all outputs 0 next cycle, config defaults, no frame_done. Scan restarts at neuron 0.
- ena toggled low for 5 cycles mid-frame: scan index and potentials frozen. frame_done arrives exactly 5 cycles late.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

  localparam logic [1:0] CFG_THRESH = 2'd0;
  localparam logic [1:0] CFG_LEAK   = 2'd1;
  localparam logic [1:0] CFG_REFRAC = 2'd2;
  localparam logic [1:0] CFG_MODE   = 2'd3;

  localparam logic [2:0] DEF_LEAK_SHIFT = 3'd2;
  localparam int         DEF_REFRAC     = 2;
  localparam logic       DEF_MODE       = 1'b0;

  // Bit of the mode register selecting subtractive (1) or reset-to-zero (0) firing.
  localparam int MODE_SUBTRACT = 0;

  // Unsigned add clamped to 2^w-1; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Input-write, config-write and spike-output bundle of the neuron array.
interface lif_neuron_array_if #(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
);
  // in_valid and cfg_we are single-cycle write strobes with no backpressure:
  // every cycle a strobe is high, the accompanying data is taken.
  logic                   in_valid;
  logic [IDX_W-1:0]       in_idx;
  logic [WIDTH-1:0]       in_current;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [WIDTH-1:0]       cfg_data;
  logic [NUM_NEURONS-1:0] spike_out;
  logic                   frame_done;
  logic [WIDTH-1:0]       potential_out;

  modport master (
    output in_valid, in_idx, in_current, cfg_we, cfg_addr, cfg_data,
    input  spike_out, frame_done, potential_out
  );

  modport slave (
    input  in_valid, in_idx, in_current, cfg_we, cfg_addr, cfg_data,
    output spike_out, frame_done, potential_out
  );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, integrate, fire and refractory handling.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 3
) (
  input  logic [WIDTH-1:0]    v,
  input  logic [WIDTH-1:0]    pending,
  input  logic [REFRAC_W-1:0] refrac,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [2:0]          leak_shift,
  input  logic [REFRAC_W-1:0] refrac_period,
  input  logic                subtract,
  output logic [WIDTH-1:0]    v_n,
  output logic [REFRAC_W-1:0] refrac_n,
  output logic                spike
);

  logic [WIDTH-1:0] leak;
  logic [WIDTH-1:0] v_sum;

  always_comb begin
    v_n      = v;
    refrac_n = refrac;
    spike    = 1'b0;
    leak     = '0;
    v_sum    = '0;
    if (refrac != '0) begin
      refrac_n = refrac - REFRAC_W'(1);
      v_n      = '0;
    end else begin
      // A shift of zero means no leak, not a full discharge.
      leak  = (leak_shift == 3'd0) ? '0 : (v >> leak_shift);
      v_sum = WIDTH'(sat_add(32'(v - leak), 32'(pending), WIDTH));
      if (v_sum >= threshold) begin
        spike    = 1'b1;
        v_n      = subtract ? (v_sum - threshold) : '0;
        refrac_n = refrac_period;
      end else begin
        v_n = v_sum;
      end
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one neuron updated per enabled cycle, one spike vector per frame.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8,
  parameter int REFRAC_W    = 3,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input logic                clk,
  input logic                rst_n,
  input logic                ena,
  lif_neuron_array_if.slave  bus
);

  localparam logic [WIDTH-1:0] DEF_THRESH = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_NEURONS - 1);

  logic [WIDTH-1:0]       v_q      [NUM_NEURONS];
  logic [WIDTH-1:0]       pend_q   [NUM_NEURONS];
  logic [REFRAC_W-1:0]    refrac_q [NUM_NEURONS];
  logic [IDX_W-1:0]       scan_idx;
  logic [NUM_NEURONS-1:0] acc_q;
  logic [NUM_NEURONS-1:0] spike_q;
  logic                   frame_done_q;
  logic [WIDTH-1:0]       potential_q;

  logic [WIDTH-1:0]       thresh_q;
  logic [2:0]             leak_shift_q;
  logic [REFRAC_W-1:0]    refrac_period_q;
  logic                   mode_q;

  logic [WIDTH-1:0]       v_n;
  logic [REFRAC_W-1:0]    refrac_n;
  logic                   spike;
  logic [NUM_NEURONS-1:0] hit;

  lif_update #(.WIDTH(WIDTH), .REFRAC_W(REFRAC_W)) u_update (
    .v             (v_q[scan_idx]),
    .pending       (pend_q[scan_idx]),
    .refrac        (refrac_q[scan_idx]),
    .threshold     (thresh_q),
    .leak_shift    (leak_shift_q),
    .refrac_period (refrac_period_q),
    .subtract      (mode_q),
    .v_n           (v_n),
    .refrac_n      (refrac_n),
    .spike         (spike)
  );

  always_comb begin
    hit = '0;
    if (spike) hit[scan_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]      <= '0;
        pend_q[i]   <= '0;
        refrac_q[i] <= '0;
      end
      scan_idx        <= '0;
      acc_q           <= '0;
      spike_q         <= '0;
      frame_done_q    <= 1'b0;
      potential_q     <= '0;
      thresh_q        <= DEF_THRESH;
      leak_shift_q    <= DEF_LEAK_SHIFT;
      refrac_period_q <= REFRAC_W'(DEF_REFRAC);
      mode_q          <= DEF_MODE;
    end else begin
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          CFG_THRESH: thresh_q        <= bus.cfg_data;
          CFG_LEAK:   leak_shift_q    <= bus.cfg_data[2:0];
          CFG_REFRAC: refrac_period_q <= bus.cfg_data[REFRAC_W-1:0];
          CFG_MODE:   mode_q          <= bus.cfg_data[MODE_SUBTRACT];
          default:    ;
        endcase
      end

      // The neuron being scanned consumes its pending current; a write landing
      // on it in the same cycle starts the next frame's accumulation.
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (bus.in_valid && bus.in_idx == IDX_W'(i)) begin
          if (ena && scan_idx == IDX_W'(i)) pend_q[i] <= bus.in_current;
          else pend_q[i] <= WIDTH'(sat_add(32'(pend_q[i]), 32'(bus.in_current), WIDTH));
        end else if (ena && scan_idx == IDX_W'(i)) begin
          pend_q[i] <= '0;
        end
      end

      frame_done_q <= 1'b0;
      if (ena) begin
        v_q[scan_idx]      <= v_n;
        refrac_q[scan_idx] <= refrac_n;
        potential_q        <= v_n;
        scan_idx           <= scan_idx + IDX_W'(1);
        if (scan_idx == LAST_IDX) begin
          spike_q      <= acc_q | hit;
          acc_q        <= '0;
          frame_done_q <= 1'b1;
        end else begin
          acc_q <= acc_q | hit;
        end
      end
    end
  end

  assign bus.spike_out     = spike_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.potential_out = potential_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed and randomized checks of lif_neuron_array against an arithmetic neuron model.
module tb_lif_neuron_array;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  lif_neuron_array_if #(.NUM_NEURONS(N), .WIDTH(W)) bus ();

  lif_neuron_array #(.NUM_NEURONS(N), .WIDTH(W), .REFRAC_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, expressed as plain integers.
  int m_v[N], m_pend[N], m_ref[N];
  int m_th, m_ls, m_rp, m_mode, m_scan, m_acc, m_spike, m_fd, m_pot;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_pend[i] = 0; m_ref[i] = 0;
    end
    m_th = 128; m_ls = 2; m_rp = 2; m_mode = 0;
    m_scan = 0; m_acc = 0; m_spike = 0; m_fd = 0; m_pot = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input bit r, input bit e, input bit iv, input int idx,
                             input int cur, input bit cw, input int ca, input int cd);
    int i, leak, vn, spk;
    if (!r) begin
      model_reset();
      return;
    end
    if (e) begin
      i = m_scan;
      spk = 0;
      if (m_ref[i] != 0) begin
        m_ref[i]--;
        m_v[i] = 0;
      end else begin
        leak = (m_ls == 0) ? 0 : (m_v[i] >> m_ls);
        vn = m_v[i] - leak + m_pend[i];
        if (vn > MAXV) vn = MAXV;
        if (vn >= m_th) begin
          spk = 1;
          m_v[i] = m_mode ? vn - m_th : 0;
          m_ref[i] = m_rp;
        end else begin
          m_v[i] = vn;
        end
      end
      m_pend[i] = 0;
      m_pot = m_v[i];
      m_acc = m_acc | (spk << i);
      if (i == N - 1) begin
        m_spike = m_acc; m_acc = 0; m_fd = 1;
      end else begin
        m_fd = 0;
      end
      m_scan = (i + 1) % N;
    end else begin
      m_fd = 0;
    end
    if (iv) begin
      m_pend[idx] = m_pend[idx] + cur;
      if (m_pend[idx] > MAXV) m_pend[idx] = MAXV;
    end
    if (cw) begin
      case (ca)
        0: m_th = cd;
        1: m_ls = cd & 7;
        2: m_rp = cd & 7;
        default: m_mode = cd & 1;
      endcase
    end
  endtask

  // One clock: drive, advance the model with the edge, then compare all outputs.
  task automatic step(input bit r, input bit e, input bit iv, input int idx, input int cur,
                      input bit cw, input int ca, input int cd);
    rst_n = r; ena = e;
    bus.in_valid = iv; bus.in_idx = idx[1:0]; bus.in_current = cur[W-1:0];
    bus.cfg_we = cw; bus.cfg_addr = ca[1:0]; bus.cfg_data = cd[W-1:0];
    @(posedge clk);
    model_cycle(r, e, iv, idx, cur, cw, ca, cd);
    #1;
    chk("spike_out", 32'(bus.spike_out), 32'(m_spike));
    chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
    chk("potential_out", 32'(bus.potential_out), 32'(m_pot));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_in(input int idx, input int cur);
    step(1, 0, 1, idx, cur, 0, 0, 0);
  endtask

  task automatic write_cfg(input int ca, input int cd);
    step(1, 0, 0, 0, 0, 1, ca, cd);
  endtask

  initial begin
    model_reset();
    bus.in_valid = 0; bus.in_idx = '0; bus.in_current = '0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;

    // Reset state
    do_reset();
    chk("reset_spike", 32'(bus.spike_out), 32'd0);
    chk("reset_fd", 32'(bus.frame_done), 32'd0);
    chk("reset_pot", 32'(bus.potential_out), 32'd0);

    // Default config: integrate 64 per frame into neuron 0
    exp_q = '{8'd64, 8'd112, 8'd0, 8'd0, 8'd0, 8'd64};
    for (int f = 1; f <= 6; f++) begin
      write_in(0, 64);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("dflt_v0", 32'(bus.potential_out), 32'(exp_q.pop_front()));
      run(3);
      chk("dflt_spike", 32'(bus.spike_out), (f == 3) ? 32'd1 : 32'd0);
      chk("dflt_fd", 32'(bus.frame_done), 32'd1);
    end

    // Subtractive reset mode
    do_reset();
    write_cfg(3, 1);
    exp_q = '{8'd64, 8'd112, 8'd20, 8'd0};
    for (int f = 1; f <= 4; f++) begin
      write_in(0, 64);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("sub_v0", 32'(bus.potential_out), 32'(exp_q.pop_front()));
      run(3);
      chk("sub_spike", 32'(bus.spike_out), (f == 3) ? 32'd1 : 32'd0);
    end

    // Input write colliding with neuron 2's update
    do_reset();
    write_in(2, 10);
    run(2);
    step(1, 1, 1, 2, 30, 0, 0, 0);
    chk("coll_this_frame", 32'(bus.potential_out), 32'd10);
    run(3);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("coll_next_frame", 32'(bus.potential_out), 32'd38);
    run(1);

    // Saturation without wrap
    do_reset();
    write_cfg(0, 255);
    write_cfg(1, 0);
    write_in(0, 200);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_v200", 32'(bus.potential_out), 32'd200);
    run(3);
    write_in(0, 200);
    write_in(0, 100);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_fire_v", 32'(bus.potential_out), 32'd0);
    run(3);
    chk("sat_spike", 32'(bus.spike_out), 32'd1);

    // Threshold zero fires every non-refractory neuron
    do_reset();
    write_cfg(0, 0);
    write_cfg(2, 0);
    run(4);
    chk("th0_spike", 32'(bus.spike_out), 32'hF);

    // Reset mid-frame restores defaults and restarts the scan
    do_reset();
    write_cfg(0, 5);
    write_in(1, 100);
    run(2);
    do_reset();
    chk("midrst_fd", 32'(bus.frame_done), 32'd0);
    chk("midrst_pot", 32'(bus.potential_out), 32'd0);
    write_in(0, 100);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("midrst_restart", 32'(bus.potential_out), 32'd100);
    run(3);
    chk("midrst_nospike", 32'(bus.spike_out), 32'd0);

    // ena low for 5 cycles mid-frame delays frame_done by 5 cycles
    do_reset();
    write_in(1, 40);
    for (int k = 0; k < 9; k++) begin
      step(1, (k < 2 || k > 6), 0, 0, 0, 0, 0, 0);
      chk("ena_fd", 32'(bus.frame_done), (k == 8) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 6) chk("ena_hold_pot", 32'(bus.potential_out), 32'd40);
    end

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1), $urandom_range(0, N - 1), $urandom_range(0, 90),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
